// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, the IF/ID slot
// layout and the fetch constants (NOP filler, PC increment).
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_slot_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and the
// instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: 32-bit instruction, 32-bit pc+4 and a valid bit,
// with load, hold (neither control) and flush-to-NOP (flush beats load).
module if_id_reg #(
    parameter logic [31:0] P_NOP = 32'hE1A0_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  fetch_pkg::fetch_slot_t i_slot,
    output fetch_pkg::fetch_slot_t o_slot,
    output logic                  o_valid
);
    import fetch_pkg::*;

    fetch_slot_t r_slot;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot.instr <= P_NOP;
            r_slot.pc4   <= '0;
            r_valid      <= 1'b0;
        end else if (i_flush) begin
            // pc4 is left alone: it is meaningless while the slot is empty
            r_slot.instr <= P_NOP;
            r_valid      <= 1'b0;
        end else if (i_load) begin
            r_slot  <= i_slot;
            r_valid <= 1'b1;
        end
    end

    assign o_slot  = r_slot;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, one-outstanding-request fetch FSM, skid buffer and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc4,
    output logic                 if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall,
    output logic [31:0]          perf_flush
`endif
);
    import fetch_pkg::*;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_addr;
    logic         r_req;
    fetch_slot_t  r_skid;

    logic         w_ack;
    logic         w_load;
    logic         w_flush;
    logic [31:0]  w_pc_inc;
    fetch_slot_t  w_load_slot;
    fetch_slot_t  w_if_id;

    assign w_ack          = imem.imem_ack & r_req;
    assign w_pc_inc       = r_pc + PC_INC;
    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;

    always_comb begin
        w_load            = 1'b0;
        w_flush           = 1'b0;
        w_load_slot.instr = imem.imem_rdata;
        w_load_slot.pc4   = w_pc_inc;
        if (branch_taken) begin
            w_flush = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!stall) begin
                        w_load  = w_ack;
                        w_flush = !w_ack;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_load      = 1'b1;
                        w_load_slot = r_skid;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= PC_RESET;
            r_addr  <= PC_RESET;
            r_req   <= 1'b0;
            r_skid  <= '0;
        end else if (branch_taken) begin
            r_pc   <= branch_target;
            r_skid <= '0;
            r_req  <= 1'b1;
            // Any request still unacked (also a second redirect while in DROP)
            // must drain before the target address may be issued.
            if (r_req && !w_ack) begin
                r_state <= ST_DROP;
            end else begin
                r_state <= ST_FETCH;
                r_addr  <= branch_target;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_req <= 1'b1;
                    if (w_ack) begin
                        r_pc   <= w_pc_inc;
                        r_addr <= w_pc_inc;
                        if (stall) begin
                            r_skid.instr <= imem.imem_rdata;
                            r_skid.pc4   <= w_pc_inc;
                            r_state      <= ST_HOLD;
                            r_req        <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (w_ack) begin
                        r_state <= ST_FETCH;
                        r_addr  <= r_pc;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .P_NOP (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_slot  (w_load_slot),
        .o_slot  (w_if_id),
        .o_valid (if_id_valid)
    );

    assign if_id_instr = w_if_id.instr;
    assign if_id_pc4   = w_if_id.pc4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + {31'd0, w_load & !w_flush};
            r_perf_stall   <= r_perf_stall + {31'd0, stall};
            r_perf_flush   <= r_perf_flush + {31'd0, branch_taken};
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
    assign perf_flush   = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers requests at random,
// a program-order model predicts what ID must receive, a monitor checks it.
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
`endif

    fetch_stage_if imem();

    fetch_stage #(
        .PC_RESET  (PC_RESET),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    fetch_slot_t exp_q[$];
    logic [31:0] fetch_pc  = PC_RESET;
    bit          stale_ok  = 1'b0;
    bit          pushed_now = 1'b0;
    bit          mon_en    = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE3A0_1001;
    endfunction

    function automatic logic [31:0] pick_target(input logic [31:0] busy);
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'h0000_0100;
            1:       t = 32'hFFFF_FFF8;
            2:       t = 32'hFFFF_FFFC;
            default: t = $urandom();
        endcase
        t[1:0] = 2'b00;
        if (t == busy) t = t + 32'h40;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock of stimulus; the program-order model is advanced for this cycle.
    task automatic drive_cycle(input bit rst, input bit stl, input bit br,
                               input logic [31:0] tgt, input bit rnd_tgt, input bit ack_en);
        logic [31:0] t;
        bit          do_ack;
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_CNT_EN
        if (mon_en) begin
            check("perf_stall", perf_stall, m_stall);
            check("perf_flush", perf_flush, m_flush);
        end
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (stl) m_stall++;
            if (br)  m_flush++;
        end
`endif
        do_ack = ack_en && (imem.imem_req === 1'b1) && !rst;
        t = rnd_tgt ? pick_target(imem.imem_addr) : tgt;
        reset           = rst;
        stall           = stl;
        branch_taken    = br;
        branch_target   = t;
        imem.imem_ack   = do_ack;
        imem.imem_rdata = do_ack ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;
        pushed_now      = 1'b0;
        if (rst) begin
            exp_q.delete();
            fetch_pc = PC_RESET;
            stale_ok = 1'b0;
        end else if (br) begin
            exp_q.delete();
            stale_ok = (imem.imem_req === 1'b1) && !do_ack;
            fetch_pc = t;
        end else if (do_ack) begin
            if (stale_ok) begin
                stale_ok = 1'b0;
            end else begin
                check("imem_addr", imem.imem_addr, fetch_pc);
                exp_q.push_back('{instr: mem_word(fetch_pc), pc4: fetch_pc + PC_INC});
                fetch_pc   = fetch_pc + PC_INC;
                pushed_now = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req",   {31'd0, imem.imem_req}, 32'd0);
        check("rst_addr",  imem.imem_addr, PC_RESET);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_instr", if_id_instr, NOP_INSTR);
        check("rst_pc4",   if_id_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
`endif
    endtask

    // Monitor: ID consumes the IF/ID slot at any edge with valid, no stall, no branch.
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_reset = 1'b1;
    logic        prev_stall = 1'b0, prev_branch = 1'b0;
    logic [31:0] prev_addr = '0;
    fetch_slot_t head;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (prev_req && !prev_ack && !prev_reset) begin
                check("req_held", {31'd0, imem.imem_req}, 32'd1);
                check("addr_stable", imem.imem_addr, prev_addr);
            end
            if (if_id_valid === 1'b1) begin
                if (!stall && !branch_taken) begin
                    if (exp_q.size() <= int'(pushed_now)) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr: got pc4=%h instr=%h required none",
                                 if_id_pc4, if_id_instr);
                    end else begin
                        head = exp_q.pop_front();
                        check("if_id_pc4", if_id_pc4, head.pc4);
                        check("if_id_instr", if_id_instr, head.instr);
                        $display("ID took pc4=%h instr=%h", if_id_pc4, if_id_instr);
                    end
                end
            end else begin
                check("empty_nop", if_id_instr, NOP_INSTR);
                if (!prev_stall && !prev_branch && !prev_reset && exp_q.size() > int'(pushed_now))
                    check("slot_filled", {31'd0, if_id_valid}, 32'd1);
            end
        end
        prev_req    = imem.imem_req;
        prev_ack    = imem.imem_ack;
        prev_addr   = imem.imem_addr;
        prev_reset  = reset;
        prev_stall  = stall;
        prev_branch = branch_taken;
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;

        // Reset, then single-cycle memory: addresses 0,4,8..., pc4 4,8,12...
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        drive_cycle(0, 0, 0, 0, 0, 1);
        check_reset_outputs();
        repeat (6) drive_cycle(0, 0, 0, 0, 0, 1);

        // Ack during a 3-cycle stall goes to the skid buffer; request drops.
        drive_cycle(0, 1, 0, 0, 0, 1);
        drive_cycle(0, 1, 0, 0, 0, 1);
        check("hold_req", {31'd0, imem.imem_req}, 32'd0);
        drive_cycle(0, 1, 0, 0, 0, 1);
        check("hold_req2", {31'd0, imem.imem_req}, 32'd0);
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 1);

        // Redirect to 0x100 with a request outstanding: its ack is discarded.
        drive_cycle(0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 32'h100, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check("drop_valid", {31'd0, if_id_valid}, 32'd0);
        check("drop_instr", if_id_instr, NOP_INSTR);
        drive_cycle(0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 1);
        check("redirect_addr", imem.imem_addr, 32'h100);
        repeat (3) drive_cycle(0, 0, 0, 0, 0, 1);

        // Branch and stall together: the branch wins.
        drive_cycle(0, 1, 1, 32'h200, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check("br_stall_valid", {31'd0, if_id_valid}, 32'd0);
        check("br_stall_addr", imem.imem_addr, 32'h200);
        repeat (2) drive_cycle(0, 0, 0, 0, 0, 1);

        // PC wrap from 0xFFFF_FFFC.
        drive_cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check("wrap_addr", imem.imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 1);

        // Reset while in HOLD: skid contents must never reach ID.
        drive_cycle(0, 1, 0, 0, 0, 1);
        drive_cycle(0, 1, 0, 0, 0, 0);
        check("hold_before_rst", {31'd0, imem.imem_req}, 32'd0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_reset_outputs();
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 9) == 0, 32'h0, 1'b1, $urandom_range(0, 3) != 0);
        end
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
